fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
REQ-002 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: imem_addr  output  32  instruction memory byte address (current PC).
REQ-005 SHALL have port: imem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port: imem_rdata  input  32  instruction word from memory, valid when imem_ack=1.
REQ-007 SHALL have port: imem_ack  input  1  memory completes the pending request this cycle.
REQ-008 SHALL have port: retire  input  1  downstream controller/datapath consumed the held instruction.
REQ-009 SHALL have port: pc_src  input  1  branch-taken select from controller, sampled only with retire.
REQ-010 SHALL have port: instr  output  32  held instruction word.
REQ-011 SHALL have port: op  output  6  instr[31:26], feeds controller op.
REQ-012 SHALL have port: func  output  6  instr[5:0], feeds controller func.
REQ-013 SHALL have port: pc_plus4  output  32  PC of held instruction plus 4.
REQ-014 SHALL have port: instr_valid  output  1  instr/op/func/pc_plus4 are valid for the controller.

Function
REQ-015 SHALL implement a two-state FSM: FETCH (imem_req=1, instr_valid=0) and HOLD (imem_req=0, instr_valid=1).
REQ-016 SHALL drive imem_addr = PC register in all states; imem_addr[1:0] always 2'b00.
REQ-017 In FETCH, on imem_ack=1 SHALL capture imem_rdata into instr at that edge and enter HOLD; instr_valid rises the following cycle.
REQ-018 In FETCH with imem_ack=0 SHALL remain in FETCH with imem_addr stable and imem_req held high (no limit on wait cycles).
REQ-019 In HOLD with retire=0 SHALL keep instr, op, func, pc_plus4, PC unchanged and imem_req=0.
REQ-020 In HOLD with retire=1 SHALL load PC with next-PC and enter FETCH the next cycle.
REQ-021 Next-PC SHALL be pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}) when pc_src=1, else pc_plus4; 32-bit modulo arithmetic, wrap at 2^32 without error.
REQ-022 retire and pc_src in FETCH SHALL be ignored; imem_ack in HOLD SHALL be ignored.
REQ-023 op and func SHALL be continuous slices of instr; pc_plus4 SHALL be PC + 4 (combinational from PC register).
REQ-024 Minimum loop: one instruction per 2 cycles (FETCH with same-cycle ack, then HOLD with retire=1).

Reset
REQ-025 On reset=1 at a rising edge SHALL set PC=RESET_PC, state=FETCH, instr=32'h0000_0000; hence instr_valid=0, imem_req=1, imem_addr=RESET_PC after the edge.
REQ-026 Reset SHALL dominate imem_ack and retire in the same cycle; a fetch in flight is discarded and reissued at RESET_PC.

Configuration
REQ-027 With macro FETCH_JUMP_EN defined, on retire of an instruction with op=6'b000010 SHALL load next-PC = {pc_plus4[31:28], instr[25:0], 2'b00}, overriding pc_src.
REQ-028 Without FETCH_JUMP_EN, op=6'b000010 SHALL receive no special handling (REQ-021 applies).

Verification
REQ-029 Reset, imem_ack=1 same cycle with rdata 32'h0232_8020 -> imem_addr 0, next cycle instr_valid=1, op=000000, func=100000, pc_plus4=4.
REQ-030 FETCH with imem_ack low 3 cycles -> imem_req=1 and imem_addr constant for 3 cycles, instr_valid=0; capture on 4th.
REQ-031 PC=8, held 32'h1000_0003 (beq), retire=1 pc_src=1 -> next imem_addr=0x18; same with pc_src=0 -> 0xC.
REQ-032 HOLD with retire=0 for 5 cycles, imem_ack toggling -> instr unchanged, imem_req=0, PC unchanged.
REQ-033 Reset asserted in FETCH with imem_ack=1 and in HOLD with retire=1 -> instr_valid=0, imem_addr=RESET_PC next cycle.
REQ-034 PC=4, held 32'h0800_0010 (j), retire=1 pc_src=0 -> next imem_addr=0x40 with FETCH_JUMP_EN, 0x8 without.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake between the fetch unit and its memory.
`timescale 1ns/1ps
interface fetch_unit_if;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_rdata;
   logic        imem_ack;

   modport master (
      output imem_addr,
      output imem_req,
      input  imem_rdata,
      input  imem_ack
   );

   modport slave (
      input  imem_addr,
      input  imem_req,
      output imem_rdata,
      output imem_ack
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: two-state FETCH/HOLD loop that fetches one word,
// holds it for the controller until retired, then advances the PC.
// Optional macro FETCH_JUMP_EN adds direct-jump (op 6'b000010) redirection.
`timescale 1ns/1ps
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         reset,
   fetch_unit_if.master imem,
   input  logic         retire,
   input  logic         pc_src,
   output logic [31:0]  instr,
   output logic [5:0]   op,
   output logic [5:0]   func,
   output logic [31:0]  pc_plus4,
   output logic         instr_valid
);

   typedef enum logic [0:0] {StFetch, StHold} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] branch_off;
   logic [31:0] pc_next;

   // Reset value keeps the PC word aligned even if a misaligned parameter is given.
   localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

   assign imem.imem_addr = pc_q;
   assign imem.imem_req  = (state_q == StFetch);
   assign instr_valid    = (state_q == StHold);
   assign instr          = instr_q;
   assign op             = instr_q[31:26];
   assign func           = instr_q[5:0];
   assign pc_plus4       = pc_q + 32'd4;

   // Next-PC select: sequential or sign-extended word-offset branch, optional jump.
   always_comb begin
      branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      pc_next    = pc_src ? (pc_plus4 + branch_off) : pc_plus4;
`ifdef FETCH_JUMP_EN
      if (instr_q[31:26] == 6'b000010) begin
         pc_next = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      end
`else
`endif
   end

   // FSM next state plus PC/instruction updates; retire ignored in FETCH, ack in HOLD.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      unique case (state_q)
         StFetch: begin
            if (imem.imem_ack) begin
               instr_d = imem.imem_rdata;
               state_d = StHold;
            end
         end
         StHold: begin
            if (retire) begin
               pc_d    = pc_next;
               state_d = StFetch;
            end
         end
         default: state_d = StFetch;
      endcase
   end

   // State registers; synchronous reset discards any in-flight fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StFetch;
         pc_q    <= ResetPcAligned;
         instr_q <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default RESET_PC = 0).
`timescale 1ns/1ps
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        retire;
   logic        pc_src;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [5:0]  func;
   logic [31:0] pc_plus4;
   logic        instr_valid;

   int checks;
   int passes;

   fetch_unit_if bus ();

   fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .imem        (bus),
      .retire      (retire),
      .pc_src      (pc_src),
      .instr       (instr),
      .op          (op),
      .func        (func),
      .pc_plus4    (pc_plus4),
      .instr_valid (instr_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle fetch with same-cycle ack.
   task automatic fetch_word(input logic [31:0] data);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = data;
      tick();
      bus.imem_ack   = 1'b0;
   endtask

   task automatic retire_word(input logic src);
      retire = 1'b1;
      pc_src = src;
      tick();
      retire = 1'b0;
      pc_src = 1'b0;
   endtask

   initial begin
      checks = 0;
      passes = 0;
      reset = 1'b1;
      retire = 1'b0;
      pc_src = 1'b0;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = 32'h0;
      tick();
      tick();
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_req", {31'b0, bus.imem_req}, 32'd1);
      chk("rst_addr", bus.imem_addr, 32'h0);
      chk("rst_instr", instr, 32'h0);

      // First fetch, ack in the same cycle as the request.
      reset = 1'b0;
      chk("f0_addr", bus.imem_addr, 32'h0);
      fetch_word(32'h0232_8020);
      chk("f0_valid", {31'b0, instr_valid}, 32'd1);
      chk("f0_op", {26'b0, op}, 32'h0);
      chk("f0_func", {26'b0, func}, 32'h20);
      chk("f0_pc4", pc_plus4, 32'h4);
      chk("f0_req", {31'b0, bus.imem_req}, 32'd0);
      retire_word(1'b0);
      chk("r0_addr", bus.imem_addr, 32'h4);
      chk("r0_valid", {31'b0, instr_valid}, 32'd0);

      // Wait states; retire/pc_src in FETCH must be ignored.
      retire = 1'b1;
      pc_src = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wait_req", {31'b0, bus.imem_req}, 32'd1);
         chk("wait_addr", bus.imem_addr, 32'h4);
         chk("wait_valid", {31'b0, instr_valid}, 32'd0);
      end
      retire = 1'b0;
      pc_src = 1'b0;
      fetch_word(32'h2002_0005);
      chk("w_instr", instr, 32'h2002_0005);
      chk("w_valid", {31'b0, instr_valid}, 32'd1);
      retire_word(1'b0);
      chk("r1_addr", bus.imem_addr, 32'h8);

      // beq at PC 8, held for 5 cycles with ack toggling.
      fetch_word(32'h1000_0003);
      for (int i = 0; i < 5; i++) begin
         bus.imem_ack = i[0] ? 1'b0 : 1'b1;
         bus.imem_rdata = 32'hDEAD_0000 + i;
         tick();
         chk("hold_instr", instr, 32'h1000_0003);
         chk("hold_req", {31'b0, bus.imem_req}, 32'd0);
         chk("hold_addr", bus.imem_addr, 32'h8);
         chk("hold_pc4", pc_plus4, 32'hC);
      end
      bus.imem_ack = 1'b0;
      retire_word(1'b1);
      chk("beq_taken", bus.imem_addr, 32'h18);

      // Reset in FETCH with ack high.
      reset = 1'b1;
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'hFFFF_FFFF;
      tick();
      reset = 1'b0;
      bus.imem_ack = 1'b0;
      chk("rf_valid", {31'b0, instr_valid}, 32'd0);
      chk("rf_addr", bus.imem_addr, 32'h0);
      chk("rf_instr", instr, 32'h0);

      // Jump at PC 4.
      fetch_word(32'h0);
      retire_word(1'b0);
      fetch_word(32'h0800_0010);
      chk("j_op", {26'b0, op}, 32'h2);
      retire_word(1'b0);
`ifdef FETCH_JUMP_EN
      chk("j_addr", bus.imem_addr, 32'h40);
`else
      chk("j_addr", bus.imem_addr, 32'h8);
`endif

      // Reset in HOLD with retire high.
      fetch_word(32'h1000_0003);
      reset = 1'b1;
      retire = 1'b1;
      pc_src = 1'b1;
      tick();
      reset = 1'b0;
      retire = 1'b0;
      pc_src = 1'b0;
      chk("rh_valid", {31'b0, instr_valid}, 32'd0);
      chk("rh_addr", bus.imem_addr, 32'h0);

      // beq not taken at PC 8.
      fetch_word(32'h0);
      retire_word(1'b0);
      fetch_word(32'h0);
      retire_word(1'b0);
      chk("nt_pre", bus.imem_addr, 32'h8);
      fetch_word(32'h1000_0003);
      retire_word(1'b0);
      chk("beq_not", bus.imem_addr, 32'hC);

      // Backward branch from PC 0 wraps below zero; pc_plus4 then wraps to 0.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      fetch_word(32'h1000_FFFE);
      retire_word(1'b1);
      chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
      fetch_word(32'h0000_0020);
      chk("wrap_pc4", pc_plus4, 32'h0);
      retire_word(1'b0);
      chk("wrap_next", bus.imem_addr, 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
